// File: rtl/ldp_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// ldp_cmd_sequencer
// Playback command sequencer for a laser-disc style player. It accepts host
// commands (PLAY/PAUSE/STEP/SEEK/STOP), walks the decoder through the
// flush -> host request -> decode-first-picture seek sequence, and tracks the
// current frame number from decoder picture-done pulses.
//
// Ports
//   sys_clk     in   clock, rising edge
//   RESET_N     in   synchronous active-low reset
//   cmd_valid   in   command present
//   cmd_ready   out  command accepted this cycle (IDLE/PLAY/PAUSE)
//   cmd_op      in   [2:0] 0 NOP,1 PLAY,2 PAUSE,3 STEP,4 SEEK,5 STOP (6-7 NOP)
//   cmd_frame   in   [16:0] SEEK target frame
//   host_req    out  level request to host stream source
//   host_frame  out  [16:0] requested frame, stable while host_req=1
//   host_ack    in   host accepted the request
//   dec_flush   out  decoder flush
//   dec_run     out  decoder enable
//   pic_done    in   one-cycle pulse per decoded picture
//   cur_frame   out  [16:0] current frame number
//   seek_err    out  one-cycle error pulse (bad target or seek timeout)
//   state       out  [2:0] encoded FSM state
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module ldp_cmd_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter logic [23:0] SEEK_TIMEOUT = 24'hFFFFFF,
  parameter logic [16:0] MAX_FRAME    = 17'd99999
) (
  input  logic        sys_clk,
  input  logic        RESET_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [16:0] cmd_frame,
  output logic        host_req,
  output logic [16:0] host_frame,
  input  logic        host_ack,
  output logic        dec_flush,
  output logic        dec_run,
  input  logic        pic_done,
  output logic [16:0] cur_frame,
  output logic        seek_err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_SEEK_REQ  = 3'd2,
    ST_SEEK_WAIT = 3'd3,
    ST_PLAY      = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_STEP      = 3'd6
  } state_e;

  localparam logic [2:0] OP_PLAY  = 3'd1;
  localparam logic [2:0] OP_PAUSE = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_SEEK  = 3'd4;
  localparam logic [2:0] OP_STOP  = 3'd5;

  // The flush counter is loaded with the last index so that dec_flush is
  // high for exactly FLUSH_CYCLES cycles in FLUSH.
  localparam logic [7:0]  FLUSH_LAST   = 8'(FLUSH_CYCLES - 1);
  // Leaving on count SEEK_TIMEOUT-1 bounds SEEK_REQ+SEEK_WAIT to SEEK_TIMEOUT
  // cycles, with seek_err appearing SEEK_TIMEOUT cycles after SEEK_REQ entry.
  localparam logic [23:0] TIMEOUT_LAST = SEEK_TIMEOUT - 24'd1;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        host_req_q, host_req_d;
  logic [16:0] host_frame_q, host_frame_d;
  logic        dec_flush_q, dec_flush_d;
  logic        dec_run_q, dec_run_d;
  logic [16:0] cur_frame_q, cur_frame_d;
  logic        seek_err_q, seek_err_d;
  logic [16:0] target_q, target_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic [23:0] to_cnt_q, to_cnt_d;
  logic        accept;

  function automatic logic [16:0] sat_inc(input logic [16:0] f);
    sat_inc = (f >= MAX_FRAME) ? MAX_FRAME : f + 17'd1;
  endfunction

  assign accept = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d      = state_q;
    host_req_d   = host_req_q;
    host_frame_d = host_frame_q;
    dec_flush_d  = 1'b0;
    dec_run_d    = dec_run_q;
    cur_frame_d  = cur_frame_q;
    seek_err_d   = 1'b0;
    target_d     = target_q;
    flush_cnt_d  = flush_cnt_q;
    to_cnt_d     = to_cnt_q;

    // State-driven progress (picture pulses, seek sequencing) is evaluated
    // first so that a command accepted in the same cycle is applied on top.
    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == 8'd0) begin
          state_d      = ST_SEEK_REQ;
          host_req_d   = 1'b1;
          host_frame_d = target_q;
          to_cnt_d     = 24'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 8'd1;
          dec_flush_d = 1'b1;
        end
      end
      ST_SEEK_REQ: begin
        if (to_cnt_q == TIMEOUT_LAST) begin
          state_d    = ST_IDLE;
          host_req_d = 1'b0;
          dec_run_d  = 1'b0;
          seek_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 24'd1;
          if (host_ack) begin
            state_d    = ST_SEEK_WAIT;
            host_req_d = 1'b0;
            dec_run_d  = 1'b1;
          end
        end
      end
      ST_SEEK_WAIT: begin
        if (pic_done) begin
          // Seek completes paused on the target frame.
          state_d     = ST_PAUSE;
          cur_frame_d = target_q;
          dec_run_d   = 1'b0;
        end else if (to_cnt_q == TIMEOUT_LAST) begin
          state_d    = ST_IDLE;
          host_req_d = 1'b0;
          dec_run_d  = 1'b0;
          seek_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 24'd1;
        end
      end
      ST_PLAY: begin
        if (pic_done) begin
          if (cur_frame_q == MAX_FRAME) begin
            // End of disc: hold the last frame and pause.
            state_d   = ST_PAUSE;
            dec_run_d = 1'b0;
          end else begin
            cur_frame_d = cur_frame_q + 17'd1;
          end
        end
      end
      ST_STEP: begin
        if (pic_done) begin
          cur_frame_d = sat_inc(cur_frame_q);
          state_d     = ST_PAUSE;
          dec_run_d   = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      case (cmd_op)
        OP_PLAY: begin
          if (state_q != ST_PLAY) begin
            state_d   = ST_PLAY;
            dec_run_d = 1'b1;
          end
        end
        OP_PAUSE: begin
          state_d   = ST_PAUSE;
          dec_run_d = 1'b0;
        end
        OP_STEP: begin
          // STEP while playing simply freezes playback.
          if (state_q == ST_PLAY) begin
            state_d   = ST_PAUSE;
            dec_run_d = 1'b0;
          end else begin
            state_d   = ST_STEP;
            dec_run_d = 1'b1;
          end
        end
        OP_SEEK: begin
          if (cmd_frame > MAX_FRAME) begin
            seek_err_d = 1'b1;
          end else begin
            target_d    = cmd_frame;
            flush_cnt_d = FLUSH_LAST;
            dec_flush_d = 1'b1;
            dec_run_d   = 1'b0;
            state_d     = ST_FLUSH;
          end
        end
        OP_STOP: begin
          state_d     = ST_IDLE;
          dec_run_d   = 1'b0;
          dec_flush_d = 1'b1;
        end
        default: ;
      endcase
    end

    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_PLAY) ||
                  (state_d == ST_PAUSE);
  end

  always_ff @(posedge sys_clk) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      host_req_q   <= 1'b0;
      host_frame_q <= 17'd0;
      dec_flush_q  <= 1'b0;
      dec_run_q    <= 1'b0;
      cur_frame_q  <= 17'd0;
      seek_err_q   <= 1'b0;
      target_q     <= 17'd0;
      flush_cnt_q  <= 8'd0;
      to_cnt_q     <= 24'd0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      host_req_q   <= host_req_d;
      host_frame_q <= host_frame_d;
      dec_flush_q  <= dec_flush_d;
      dec_run_q    <= dec_run_d;
      cur_frame_q  <= cur_frame_d;
      seek_err_q   <= seek_err_d;
      target_q     <= target_d;
      flush_cnt_q  <= flush_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign host_req   = host_req_q;
  assign host_frame = host_frame_q;
  assign dec_flush  = dec_flush_q;
  assign dec_run    = dec_run_q;
  assign cur_frame  = cur_frame_q;
  assign seek_err   = seek_err_q;
  assign state      = state_q;

endmodule
